// File: rtl/pulse_ratio_detector.sv
// Measures the spacing of a single-cycle pulse train and locks onto a
// stable interval, reporting the recovered ratio and loss-of-lock events.
module pulse_ratio_detector #(
   parameter int MAX_RATIO = 16,
   parameter int LOCK_COUNT = 4,
   localparam int RW = $clog2(MAX_RATIO + 1)
) (
   input  logic          clk_in,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          pulse_in,
   output logic [RW-1:0] ratio,
   output logic          locked,
   output logic          lock_pulse,
   output logic          err
);

   localparam int MW = $clog2(LOCK_COUNT + 1);
   localparam logic [RW-1:0] MAXC = RW'(MAX_RATIO);
   localparam logic [MW-1:0] LOCKC = MW'(LOCK_COUNT);

   typedef enum logic [1:0] {
      IDLE,
      MEASURE,
      LOCKED
   } state_t;

   state_t state, state_nxt;
   logic [RW-1:0] cnt, cnt_nxt;
   logic [RW-1:0] cand, cand_nxt;
   logic [MW-1:0] match, match_nxt;
   logic [RW-1:0] ratio_nxt;
   logic          locked_nxt;
   logic          lock_pulse_nxt;
   logic          err_nxt;
   logic          tmo;
   logic          slip;

   // cnt holds the interval since the last pulse; it saturates at MAX_RATIO
   assign tmo  = !pulse_in && (cnt == MAXC) && (state != IDLE);
   assign slip = (state == LOCKED) && pulse_in && (cnt != ratio);

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= '0;
         cand       <= '0;
         match      <= '0;
         ratio      <= '0;
         locked     <= 1'b0;
         lock_pulse <= 1'b0;
         err        <= 1'b0;
      end else if (clear) begin
         state      <= IDLE;
         cnt        <= '0;
         cand       <= '0;
         match      <= '0;
         ratio      <= '0;
         locked     <= 1'b0;
         lock_pulse <= 1'b0;
         err        <= 1'b0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         cand       <= cand_nxt;
         match      <= match_nxt;
         ratio      <= ratio_nxt;
         locked     <= locked_nxt;
         lock_pulse <= lock_pulse_nxt;
         err        <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cand_nxt  = cand;
      match_nxt = match;
      if (pulse_in)
         cnt_nxt = RW'(1);
      else if (cnt == MAXC)
         cnt_nxt = cnt;
      else
         cnt_nxt = cnt + 1'b1;
      unique case (state)
         IDLE: begin
            if (pulse_in) begin
               state_nxt = MEASURE;
               match_nxt = '0;
            end
         end
         MEASURE: begin
            if (tmo) begin
               state_nxt = IDLE;
               match_nxt = '0;
            end else if (pulse_in) begin
               if (match == '0 || cnt != cand) begin
                  cand_nxt  = cnt;
                  match_nxt = MW'(1);
               end else if (match != LOCKC) begin
                  match_nxt = match + 1'b1;
               end
               if (match_nxt == LOCKC)
                  state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (tmo) begin
               state_nxt = IDLE;
               match_nxt = '0;
            end else if (slip) begin
               state_nxt = MEASURE;
               cand_nxt  = cnt;
               match_nxt = MW'(1);
            end
         end
         default: begin
            state_nxt = IDLE;
            match_nxt = '0;
         end
      endcase
   end

   always_comb begin
      lock_pulse_nxt = (state == MEASURE) && (state_nxt == LOCKED);
      err_nxt        = tmo || slip;
      locked_nxt     = (state_nxt == LOCKED);
      ratio_nxt      = '0;
      if (locked_nxt)
         ratio_nxt = (state == LOCKED) ? ratio : cand_nxt;
   end

endmodule

// File: tb/tb_pulse_ratio_detector.sv
// Bench for pulse_ratio_detector: vector table, directed corner sequences
// and a randomized pulse-train run against an interval-history model.
module tb_pulse_ratio_detector;

   localparam int MAXR = 16;
   localparam int LC = 4;
   localparam int RW = $clog2(MAXR + 1);

   logic          clk_in = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          pulse_in = 1'b0;
   logic [RW-1:0] ratio;
   logic          locked;
   logic          lock_pulse;
   logic          err;

   pulse_ratio_detector #(.MAX_RATIO(MAXR), .LOCK_COUNT(LC)) dut (
      .clk_in(clk_in),
      .rst_n(rst_n),
      .clear(clear),
      .pulse_in(pulse_in),
      .ratio(ratio),
      .locked(locked),
      .lock_pulse(lock_pulse),
      .err(err)
   );

   always #5 clk_in = ~clk_in;

   int errors = 0;
   int checks = 0;

   // model: intervals since the last break are kept in a queue
   int m_active, m_since, m_locked, m_ratio, m_lp, m_err;
   int hist[$];

   typedef struct {
      bit p;
      bit c;
      int e_locked;
      int e_lp;
      int e_err;
      int e_ratio;
   } vec_t;
   vec_t tbl[14];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0;
      m_since = 0;
      m_locked = 0;
      m_ratio = 0;
      m_lp = 0;
      m_err = 0;
      hist.delete();
   endtask

   task automatic model_step(input bit p, input bit c);
      int iv;
      bit same;
      if (c) begin
         model_reset();
         return;
      end
      m_lp = 0;
      m_err = 0;
      if (p) begin
         iv = m_since;
         m_since = 1;
         if (!m_active) begin
            m_active = 1;
            hist.delete();
         end else if (m_locked) begin
            if (iv != m_ratio) begin
               m_err = 1;
               m_locked = 0;
               m_ratio = 0;
               hist.delete();
               hist.push_back(iv);
            end
         end else begin
            hist.push_back(iv);
            if (hist.size() >= LC) begin
               same = 1;
               for (int k = hist.size() - LC; k < hist.size(); k++)
                  if (hist[k] != iv) same = 0;
               if (same) begin
                  m_locked = 1;
                  m_ratio = iv;
                  m_lp = 1;
               end
            end
         end
      end else if (m_active && m_since == MAXR) begin
         m_err = 1;
         m_active = 0;
         m_locked = 0;
         m_ratio = 0;
         hist.delete();
      end else if (m_since < MAXR) begin
         m_since++;
      end
   endtask

   task automatic step(input bit p, input bit c);
      pulse_in = p;
      clear = c;
      @(posedge clk_in);
      model_step(p, c);
      #1;
      chk("locked", int'(locked), m_locked);
      chk("lock_pulse", int'(lock_pulse), m_lp);
      chk("err", int'(err), m_err);
      chk("ratio", int'(ratio), m_ratio);
      chk("strobe_excl", int'(lock_pulse & err), 0);
   endtask

   task automatic gap(input int n);
      for (int k = 0; k < n - 1; k++) step(1'b0, 1'b0);
      step(1'b1, 1'b0);
   endtask

   task automatic train(input int per, input int n);
      step(1'b1, 1'b0);
      for (int k = 0; k < n - 1; k++) gap(per);
   endtask

   initial begin
      int saw;
      int tcy;
      model_reset();
      for (int i = 0; i < 14; i++) begin
         tbl[i].p = (i % 3 == 0) && (i <= 12);
         tbl[i].c = 1'b0;
         tbl[i].e_locked = (i >= 12) ? 1 : 0;
         tbl[i].e_lp = (i == 12) ? 1 : 0;
         tbl[i].e_err = 0;
         tbl[i].e_ratio = (i >= 12) ? 3 : 0;
      end

      #2;
      chk("rst_locked", int'(locked), 0);
      chk("rst_ratio", int'(ratio), 0);
      chk("rst_lp", int'(lock_pulse), 0);
      chk("rst_err", int'(err), 0);
      #10 rst_n = 1'b1;

      // 1: pulses every 3 cycles
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].p, tbl[i].c);
         chk($sformatf("t1_locked[%0d]", i), int'(locked), tbl[i].e_locked);
         chk($sformatf("t1_lp[%0d]", i), int'(lock_pulse), tbl[i].e_lp);
         chk($sformatf("t1_err[%0d]", i), int'(err), tbl[i].e_err);
         chk($sformatf("t1_ratio[%0d]", i), int'(ratio), tbl[i].e_ratio);
      end

      // 2: pulse_in held high
      step(1'b0, 1'b1);
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
      chk("t2_prelock", int'(locked), 0);
      step(1'b1, 1'b0);
      chk("t2_locked", int'(locked), 1);
      chk("t2_ratio", int'(ratio), 1);
      saw = 0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0);
         if (err) saw = 1;
      end
      chk("t2_noerr", saw, 0);

      // 3: slip from 4 to 5 and relock
      step(1'b0, 1'b1);
      train(4, 5);
      chk("t3_locked4", int'(ratio), 4);
      gap(5);
      chk("t3_err", int'(err), 1);
      chk("t3_unlock", int'(locked), 0);
      chk("t3_ratio0", int'(ratio), 0);
      gap(5);
      chk("t3_err_clr", int'(err), 0);
      gap(5);
      chk("t3_notyet", int'(locked), 0);
      gap(5);
      chk("t3_relock", int'(locked), 1);
      chk("t3_ratio5", int'(ratio), 5);
      chk("t3_lp", int'(lock_pulse), 1);

      // 4: timeout then lock at MAX_RATIO
      step(1'b0, 1'b1);
      train(4, 5);
      tcy = -1;
      for (int i = 1; i <= 40 && tcy < 0; i++) begin
         step(1'b0, 1'b0);
         if (err) tcy = i;
      end
      chk("t4_timeout_cycle", tcy, 16);
      chk("t4_unlock", int'(locked), 0);
      chk("t4_ratio0", int'(ratio), 0);
      train(16, 5);
      chk("t4_lock16", int'(locked), 1);
      chk("t4_ratio16", int'(ratio), 16);
      saw = 0;
      for (int i = 0; i < 3 * 16; i++) begin
         step((i % 16) == 15, 1'b0);
         if (err) saw = 1;
      end
      chk("t4_noerr16", saw, 0);
      chk("t4_still", int'(locked), 1);

      // 5: clear on the locking edge
      step(1'b0, 1'b1);
      train(2, 4);
      step(1'b0, 1'b0);
      step(1'b1, 1'b1);
      chk("t5_locked", int'(locked), 0);
      chk("t5_lp", int'(lock_pulse), 0);
      chk("t5_err", int'(err), 0);
      train(2, 5);
      chk("t5_relock", int'(locked), 1);
      chk("t5_ratio2", int'(ratio), 2);

      // 6: async reset while locked and mid-measure
      #3 rst_n = 1'b0;
      #1;
      chk("t6_async_locked", int'(locked), 0);
      chk("t6_async_ratio", int'(ratio), 0);
      model_reset();
      #2 rst_n = 1'b1;
      train(3, 3);
      #3 rst_n = 1'b0;
      #1;
      chk("t6_mid_locked", int'(locked), 0);
      model_reset();
      #2 rst_n = 1'b1;
      train(3, 4);
      chk("t6_four", int'(locked), 0);
      gap(3);
      chk("t6_five", int'(locked), 1);
      chk("t6_ratio3", int'(ratio), 3);

      // random periodic trains with jitter, gaps and clears
      step(1'b0, 1'b1);
      for (int s = 0; s < 120; s++) begin
         int per;
         int n;
         per = $urandom_range(1, 18);
         n = $urandom_range(1, 8);
         for (int k = 0; k < n; k++) begin
            int g;
            g = per;
            if ($urandom_range(0, 5) == 0)
               g = ($urandom_range(0, 1) == 0) ? per + 1 : per - 1;
            if (g < 1) g = 1;
            for (int z = 0; z < g - 1; z++)
               step(1'b0, $urandom_range(0, 199) == 0);
            step(1'b1, $urandom_range(0, 199) == 0);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
